mem_arbiter: RTL

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage (read-only requester) and the memory stage (read/write requester) of the five-stage pipeline. Sits between the stage logic and the memory model/bus, serialises requests with at most one transaction outstanding, and returns responses to the owning requester. Data requests have priority; an optional anti-starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data requester ports and memory bus of the arbiter.
// The arbiter takes the slave view; the surrounding stages and memory drive the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                if_req;
   logic [ADDR_W-1:0]   if_addr;
   logic                if_rvalid;
   logic [DATA_W-1:0]   if_rdata;
   logic                dm_req;
   logic                dm_we;
   logic [ADDR_W-1:0]   dm_addr;
   logic [DATA_W-1:0]   dm_wdata;
   logic [DATA_W/8-1:0] dm_be;
   logic                dm_rvalid;
   logic [DATA_W-1:0]   dm_rdata;
   logic                mem_valid;
   logic                mem_ready;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_be;
   logic                mem_rvalid;
   logic [DATA_W-1:0]   mem_rdata;
   logic                busy;
   logic                stray_rsp;
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ready, mem_rvalid, mem_rdata,
      output if_rvalid, if_rdata, dm_rvalid, dm_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
             busy, stray_rsp
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ready, mem_rvalid, mem_rdata,
      input  if_rvalid, if_rdata, dm_rvalid, dm_rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
             busy, stray_rsp
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data stages, one transaction outstanding.
// Data wins by default; define MEM_ARB_STARVE_GUARD_EN to bound how long fetch can be locked out.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              stray_q, stray_d;
   logic              any_req, force_if, pick_if, rsp;
   assign any_req = bus.if_req | bus.dm_req;
   assign pick_if = bus.if_req & (~bus.dm_req | force_if);
   assign rsp     = (state_q == WAIT) & bus.mem_rvalid;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Counting stops at STARVE_MAX because that value forces the next grant to fetch, which clears it.
   assign force_if = cnt_q == CNT_W'(STARVE_MAX);
   assign cnt_d    = (state_q != IDLE) ? cnt_q : (!bus.if_req || pick_if) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
   assign force_if = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         stray_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         stray_q <= stray_d;
      end
   end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      stray_d = stray_q | (bus.mem_rvalid & (state_q != WAIT));
      if (state_q == IDLE && any_req) begin
         state_d = REQ;
         owner_d = ~pick_if;
         we_d    = ~pick_if & bus.dm_we;
         addr_d  = pick_if ? bus.if_addr : bus.dm_addr;
         wdata_d = pick_if ? '0 : bus.dm_wdata;
         be_d    = pick_if ? '1 : bus.dm_be;
      end
      if (state_q == REQ && bus.mem_ready) state_d = WAIT;
      if (rsp) state_d = IDLE;
   end
   always_comb begin
      bus.mem_valid = state_q == REQ;
      bus.busy      = state_q != IDLE;
      bus.if_rvalid = rsp & ~owner_q;
      bus.dm_rvalid = rsp & owner_q;
      bus.if_rdata  = (rsp & ~owner_q) ? bus.mem_rdata : '0;
      bus.dm_rdata  = (rsp & owner_q) ? bus.mem_rdata : '0;
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_be    = be_q;
      bus.stray_rsp = stray_q;
   end
endmodule
